// File: rtl/complete_arbiter_pkg.sv
// Shared types and defaults for the complete-stage arbiter.
// Packet layout is shared with the FUs and passes through the arbiter untouched.
package complete_arbiter_pkg;

    localparam int NUM_FU_DEF = 4;
    localparam int CDB_W_DEF  = 2;

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic        take_branch;
        logic [31:0] target_pc;
        logic [31:0] dest_value;
        logic [4:0]  rob_idx;
        logic        rd_mem;
        logic        wr_mem;
    } FU_COMPLETE_PACKET;

    typedef FU_COMPLETE_PACKET CDB_PACKET;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/complete_arbiter_if.sv
// FU-result / CDB bundle between the functional units and the complete arbiter.
// master = FU side (drives results, sees stalls and CDB), slave = arbiter.
interface complete_arbiter_if #(
    parameter int NUM_FU = complete_arbiter_pkg::NUM_FU_DEF,
    parameter int CDB_W  = complete_arbiter_pkg::CDB_W_DEF
) ();
    import complete_arbiter_pkg::*;

    localparam int CNT_W = $clog2(NUM_FU + 1);

    logic                             squash;
    logic              [NUM_FU-1:0]   fu_want_to_complete;
    FU_COMPLETE_PACKET [NUM_FU-1:0]   fu_packet_in;
    logic              [NUM_FU-1:0]   fu_stall;
    logic              [CDB_W-1:0]    cdb_valid;
    CDB_PACKET         [CDB_W-1:0]    cdb_packet_out;
    logic              [CNT_W-1:0]    pending_count;

    modport master (
        output squash, fu_want_to_complete, fu_packet_in,
        input  fu_stall, cdb_valid, cdb_packet_out, pending_count
    );

    modport slave (
        input  squash, fu_want_to_complete, fu_packet_in,
        output fu_stall, cdb_valid, cdb_packet_out, pending_count
    );

endinterface

// File: rtl/complete_arbiter_rr_select.sv
// Circular multi-grant picker: up to CDB_W requests starting at start_ptr, lane k gets the k-th hit.
// Purely combinational, no backpressure of its own.
module rr_select #(
    parameter int NUM_FU = 4,
    parameter int CDB_W  = 2,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_FU-1:0]             req,
    input  logic [PTR_W-1:0]              start_ptr,
    output logic [CDB_W-1:0][NUM_FU-1:0]  lane_grant,
    output logic [CDB_W-1:0]              lane_vld,
    output logic [PTR_W-1:0]              last_idx
);

    logic [NUM_FU-1:0] avail;
    logic [PTR_W-1:0]  idx;

    function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base, input int off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + (PTR_W+1)'(off);
        if (sum >= (PTR_W+1)'(NUM_FU)) begin
            sum = sum - (PTR_W+1)'(NUM_FU);
        end
        return sum[PTR_W-1:0];
    endfunction

    // Lanes fill in scan order, so the last granted slot is the highest lane's pick.
    always_comb begin
        lane_grant = '0;
        lane_vld   = '0;
        last_idx   = start_ptr;
        avail      = req;
        idx        = '0;
        for (int k = 0; k < CDB_W; k++) begin
            for (int off = 0; off < NUM_FU; off++) begin
                idx = scan_idx(start_ptr, off);
                if (!lane_vld[k] && avail[idx]) begin
                    lane_grant[k][idx] = 1'b1;
                    lane_vld[k]        = 1'b1;
                    avail[idx]         = 1'b0;
                    last_idx           = idx;
                end
            end
        end
    end

endmodule

// File: rtl/complete_arbiter.sv
// One result slot per FU, round-robin onto CDB_W lanes; 1-cycle min latency, slot refills on grant.
// fu_stall[i] while slot i is held and not granted; squash drops slots and the cycle's inputs.
module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEF,
    parameter int CDB_W  = CDB_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    complete_arbiter_if.slave bus
);

    localparam int PTR_W = ptr_w(NUM_FU);
    localparam int CNT_W = $clog2(NUM_FU + 1);

    logic              [NUM_FU-1:0]  slot_vld_q,  slot_vld_d;
    FU_COMPLETE_PACKET [NUM_FU-1:0]  slot_pkt_q,  slot_pkt_d;
    logic              [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic              [CNT_W-1:0]   pending_count_q, pending_count_d;

    logic [CDB_W-1:0][NUM_FU-1:0] lane_grant;
    logic [CDB_W-1:0]             lane_vld;
    logic [PTR_W-1:0]             last_idx;
    logic [NUM_FU-1:0]            slot_grant;
    CDB_PACKET [CDB_W-1:0]        cdb_pkt;

    rr_select #(
        .NUM_FU (NUM_FU),
        .CDB_W  (CDB_W),
        .PTR_W  (PTR_W)
    ) u_rr_select (
        .req        (slot_vld_q),
        .start_ptr  (rr_ptr_q),
        .lane_grant (lane_grant),
        .lane_vld   (lane_vld),
        .last_idx   (last_idx)
    );

    always_comb begin
        slot_grant = '0;
        cdb_pkt    = '0;
        for (int k = 0; k < CDB_W; k++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (lane_grant[k][i]) begin
                    slot_grant[i] = 1'b1;
                    cdb_pkt[k]    = slot_pkt_q[i];
                end
            end
        end
    end

    // Outputs come from registered slots; only squash reaches them combinationally.
    assign bus.cdb_valid      = bus.squash ? '0 : lane_vld;
    assign bus.cdb_packet_out = cdb_pkt;
    assign bus.fu_stall       = bus.squash ? '0 : (slot_vld_q & ~slot_grant);
    assign bus.pending_count  = pending_count_q;

    always_comb begin
        slot_vld_d      = slot_vld_q;
        slot_pkt_d      = slot_pkt_q;
        rr_ptr_d        = rr_ptr_q;
        pending_count_d = '0;
        if (bus.squash) begin
            slot_vld_d = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if ((slot_grant[i] || !slot_vld_q[i]) && bus.fu_want_to_complete[i]) begin
                    slot_vld_d[i] = 1'b1;
                    slot_pkt_d[i] = bus.fu_packet_in[i];
                end else if (slot_grant[i]) begin
                    slot_vld_d[i] = 1'b0;
                end
            end
            if (|lane_vld) begin
                rr_ptr_d = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            pending_count_d = pending_count_d + CNT_W'(slot_vld_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_vld_q      <= '0;
            slot_pkt_q      <= '0;
            rr_ptr_q        <= '0;
            pending_count_q <= '0;
        end else begin
            slot_vld_q      <= slot_vld_d;
            slot_pkt_q      <= slot_pkt_d;
            rr_ptr_q        <= rr_ptr_d;
            pending_count_q <= pending_count_d;
        end
    end

endmodule
